// File: rtl/rr_arb_pkg.sv
// Shared constants and state encoding for the four-client round-robin arbiter.
package rr_arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/dec2to4.sv
// Enable-gated 2-to-4 one-hot decoder.
module dec2to4 (
  input  logic [1:0] sel,
  input  logic       en,
  output logic [3:0] y
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dec
      assign y[gi] = en && (sel == 2'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set request after ptr, wrapping 3->0,
// optionally ignoring one index (the current grantee when forcing rotation).
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             excl_en,
  input  logic [IDX_W-1:0] excl_idx,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] cand_req;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_mask
      assign cand_req[gi] = req[gi] & ~(excl_en && (excl_idx == IDX_W'(gi)));
    end
  endgenerate

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    for (int k = N_REQ; k >= 1; k--) begin
      if (cand_req[ptr + IDX_W'(k)]) begin
        found = 1'b1;
        idx   = ptr + IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered winner, one-hot grant
// and an optional per-tenure hold limit applied only under contention.
module rr_arbiter4
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  localparam bit              HOLD_EN  = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  state_t           state_reg;
  logic [IDX_W-1:0] cur_idx_reg;
  logic [IDX_W-1:0] last_idx_reg;
  logic [CNT_W-1:0] hold_cnt_reg;

  logic             busy;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             hold_expired;

  assign busy         = (state_reg == ST_BUSY);
  assign hold_expired = HOLD_EN && (hold_cnt_reg >= HOLD_LIM);

  // While busy the grantee is excluded, so pick_found means "someone else waits".
  rr_pick4 u_pick (
    .req      (req),
    .ptr      (last_idx_reg),
    .excl_en  (busy),
    .excl_idx (cur_idx_reg),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cur_idx_reg  <= '0;
      last_idx_reg <= '1;
      hold_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_found) begin
            state_reg    <= ST_BUSY;
            cur_idx_reg  <= pick_idx;
            last_idx_reg <= pick_idx;
            hold_cnt_reg <= CNT_W'(1);
          end
        end
        ST_BUSY: begin
          if (req[cur_idx_reg] && !(hold_expired && pick_found)) begin
            if (hold_cnt_reg != '1) begin
              hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
            end
          end else if (pick_found) begin
            cur_idx_reg  <= pick_idx;
            last_idx_reg <= pick_idx;
            hold_cnt_reg <= CNT_W'(1);
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  dec2to4 u_dec (
    .sel (cur_idx_reg),
    .en  (busy),
    .y   (grant)
  );

  assign grant_idx   = cur_idx_reg;
  assign grant_valid = busy;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed and randomized checks of rr_arbiter4 with hold limits 0, 3 and 4.
module tb_rr_arbiter4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic [3:0] req_a = '0, req_b = '0, req_c = '0;
  logic [3:0] grant_a, grant_b, grant_c;
  logic [1:0] idx_a, idx_b, idx_c;
  logic       valid_a, valid_b, valid_c;

  rr_arbiter4 #(.MAX_HOLD(0)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a),
    .grant(grant_a), .grant_idx(idx_a), .grant_valid(valid_a)
  );
  rr_arbiter4 #(.MAX_HOLD(3)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b),
    .grant(grant_b), .grant_idx(idx_b), .grant_valid(valid_b)
  );
  rr_arbiter4 #(.MAX_HOLD(4)) dut_c (
    .clk(clk), .rst(rst_c), .req(req_c),
    .grant(grant_c), .grant_idx(idx_c), .grant_valid(valid_c)
  );

  typedef struct {
    int         unit;
    logic       chk_idx;
    logic [3:0] grant;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] enc(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (g[i]) r = 2'(i);
    return r;
  endfunction

  // Drive one cycle of stimulus, queue the expected grant, compare after the edge.
  task automatic step(input int unit, input logic rs, input logic [3:0] r,
                      input logic [3:0] g, input string tag);
    exp_t       e;
    logic [3:0] og;
    logic [1:0] oi;
    logic       ov;
    if (unit == 0) begin rst_a = rs; req_a = r; end
    else           begin rst_b = rs; req_b = r; end
    e.unit = unit; e.chk_idx = rs || (g != 4'b0000); e.grant = g; e.tag = tag;
    sb.push_back(e);
    @(posedge clk); #1;
    e  = sb.pop_front();
    og = (e.unit == 0) ? grant_a : grant_b;
    oi = (e.unit == 0) ? idx_a   : idx_b;
    ov = (e.unit == 0) ? valid_a : valid_b;
    check({e.tag, ".grant"}, og, e.grant);
    check({e.tag, ".valid"}, ov, |e.grant);
    if (e.chk_idx) check({e.tag, ".idx"}, oi, enc(e.grant));
  endtask

  int wait_c[4];
  int max_wait[4];

  initial begin
    // Unit A: no hold limit
    step(0, 1'b1, 4'b0000, 4'b0000, "a_reset");
    step(0, 1'b0, 4'b1111, 4'b0001, "a_all_first");
    step(0, 1'b0, 4'b1111, 4'b0001, "a_all_hold");
    step(0, 1'b0, 4'b1110, 4'b0010, "a_rel0");
    step(0, 1'b0, 4'b1101, 4'b0100, "a_rel1");
    step(0, 1'b0, 4'b1011, 4'b1000, "a_rel2");
    step(0, 1'b0, 4'b0111, 4'b0001, "a_rel3");
    step(0, 1'b0, 4'b0000, 4'b0000, "a_idle");
    step(0, 1'b0, 4'b0000, 4'b0000, "a_idle_stay");
    step(0, 1'b0, 4'b0100, 4'b0100, "a_single2");
    step(0, 1'b0, 4'b0000, 4'b0000, "a_drop2");
    step(0, 1'b0, 4'b1000, 4'b1000, "a_single3");
    step(0, 1'b0, 4'b0000, 4'b0000, "a_drop3");
    step(0, 1'b0, 4'b0110, 4'b0010, "a_simul_first");
    step(0, 1'b0, 4'b0100, 4'b0100, "a_simul_next");
    step(0, 1'b1, 4'b0100, 4'b0000, "a_rst_mid");
    step(0, 1'b0, 4'b0101, 4'b0001, "a_rst_prio");
    step(0, 1'b0, 4'b0100, 4'b0100, "a_after_prio");

    // Unit B: hold limit of 3
    step(1, 1'b1, 4'b0000, 4'b0000, "b_reset");
    for (int i = 0; i < 3; i++) step(1, 1'b0, 4'b1010, 4'b0010, "b_tenure1");
    for (int i = 0; i < 3; i++) step(1, 1'b0, 4'b1010, 4'b1000, "b_tenure3");
    step(1, 1'b0, 4'b1010, 4'b0010, "b_back1");
    for (int i = 0; i < 22; i++) step(1, 1'b0, 4'b0010, 4'b0010, "b_lone");
    step(1, 1'b0, 4'b1010, 4'b1000, "b_limit_now");

    // Unit C: hold limit of 4, random traffic then constant contention
    rst_c = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) req_c[b] = ~req_c[b];
      @(posedge clk); #1;
      check("c_onehot0", 32'($onehot0(grant_c)), 32'd1);
      check("c_only_requesters", 32'(grant_c & ~req_c), 32'd0);
      check("c_valid", 32'(valid_c), 32'(|grant_c));
    end
    req_c = 4'b1111;
    for (int i = 0; i < 4; i++) begin wait_c[i] = 0; max_wait[i] = 0; end
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (grant_c[i]) wait_c[i] = 0;
        else            wait_c[i]++;
        if (wait_c[i] > max_wait[i]) max_wait[i] = wait_c[i];
      end
    end
    for (int i = 0; i < 4; i++) check($sformatf("c_max_wait%0d", i), 32'(max_wait[i]), 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
